// File: rtl/dram_line_reader.sv
// AXI4 read master: splits a kick request into 4 KB-safe INCR bursts and
// streams the returned 32-bit words out as buf_dout/buf_we.
module dram_line_reader #(
    parameter int MAX_BURST = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_kick,
    input  logic [31:0] i_read_addr,
    input  logic [31:0] i_read_num,
    output logic        o_busy,
    output logic [31:0] o_buf_dout,
    output logic        o_buf_we,
    output logic        o_rd_err,
    output logic [31:0] o_m_axi_araddr,
    output logic [7:0]  o_m_axi_arlen,
    output logic [2:0]  o_m_axi_arsize,
    output logic [1:0]  o_m_axi_arburst,
    output logic        o_m_axi_arvalid,
    input  logic        i_m_axi_arready,
    input  logic [31:0] i_m_axi_rdata,
    input  logic [1:0]  i_m_axi_rresp,
    input  logic        i_m_axi_rlast,
    input  logic        i_m_axi_rvalid,
    output logic        o_m_axi_rready
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADDR, S_DATA} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_kick_d;
    logic [31:0] r_addr;
    logic [31:0] r_remain;
    logic [7:0]  r_bcnt;
    logic [7:0]  r_arlen;
    logic [31:0] r_araddr;
    logic [31:0] r_buf_dout;
    logic        r_buf_we;
    logic        r_rd_err;

    logic        w_start;
    logic        w_beat;
    logic        w_last_beat;
    logic [10:0] w_to4k;
    logic [10:0] w_lim;
    logic [10:0] w_beats;
    logic [8:0]  w_burst_len;

    assign w_start     = i_kick & ~r_kick_d & (i_read_num != 32'd0);
    assign w_to4k      = 11'd1024 - {1'b0, r_addr[11:2]};
    assign w_lim       = (11'(MAX_BURST) < w_to4k) ? 11'(MAX_BURST) : w_to4k;
    assign w_beats     = (r_remain < {21'd0, w_lim}) ? r_remain[10:0] : w_lim;
    assign w_burst_len = {1'b0, r_arlen} + 9'd1;
    assign w_beat      = (r_state == S_DATA) & i_m_axi_rvalid;
    assign w_last_beat = w_beat & (r_bcnt == r_arlen);

    assign o_buf_dout      = r_buf_dout;
    assign o_buf_we        = r_buf_we;
    assign o_rd_err        = r_rd_err;
    assign o_m_axi_araddr  = r_araddr;
    assign o_m_axi_arlen   = r_arlen;
    assign o_m_axi_arsize  = 3'b010;
    assign o_m_axi_arburst = 2'b01;

    always_comb begin
        w_next          = r_state;
        o_busy          = 1'b1;
        o_m_axi_arvalid = 1'b0;
        o_m_axi_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_start) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                w_next = S_ADDR;
            end
            S_ADDR: begin
                o_m_axi_arvalid = 1'b1;
                if (i_m_axi_arready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                o_m_axi_rready = 1'b1;
                // remain already excludes the current burst, so zero means done
                if (w_last_beat) begin
                    w_next = (r_remain == 32'd0) ? S_IDLE : S_CALC;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_kick_d   <= 1'b0;
            r_addr     <= 32'd0;
            r_remain   <= 32'd0;
            r_bcnt     <= 8'd0;
            r_arlen    <= 8'd0;
            r_araddr   <= 32'd0;
            r_buf_dout <= 32'd0;
            r_buf_we   <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_kick_d   <= i_kick;
            r_buf_dout <= i_m_axi_rdata;
            r_buf_we   <= w_beat;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr   <= i_read_addr & 32'hFFFF_FFFC;
                        r_remain <= i_read_num;
                    end
                end
                S_CALC: begin
                    r_araddr <= r_addr;
                    r_arlen  <= 8'(w_beats - 11'd1);
                end
                S_ADDR: begin
                    if (i_m_axi_arready) begin
                        r_addr   <= r_addr + {21'd0, w_burst_len, 2'b00};
                        r_remain <= r_remain - {23'd0, w_burst_len};
                        r_bcnt   <= 8'd0;
                    end
                end
                S_DATA: begin
                    // termination follows the beat count; rlast is only audited
                    if (w_beat) begin
                        r_bcnt <= r_bcnt + 8'd1;
                        if ((i_m_axi_rresp != 2'b00) ||
                            (i_m_axi_rlast != (r_bcnt == r_arlen))) begin
                            r_rd_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_line_reader.sv
// Self-checking bench for dram_line_reader: an AXI read slave backed by a
// synthetic DRAM model plus a scoreboard of expected output words.
module tb_dram_line_reader;

    localparam int MAX_BURST = 256;

    logic        clk = 1'b0;
    logic        rstN;
    logic        kick;
    logic [31:0] readAddr;
    logic [31:0] readNum;
    logic        busy;
    logic [31:0] bufDout;
    logic        bufWe;
    logic        rdErr;
    logic [31:0] arAddr;
    logic [7:0]  arLen;
    logic [2:0]  arSize;
    logic [1:0]  arBurst;
    logic        arValid;
    logic        arReady;
    logic [31:0] rData;
    logic [1:0]  rResp;
    logic        rLast;
    logic        rValid;
    logic        rReady;

    int errors = 0;
    int checks = 0;

    logic [31:0] expQ[$];
    logic [31:0] obsQ[$];
    logic [31:0] arAddrQ[$];
    logic [7:0]  arLenQ[$];
    int          obsIdx = 0;
    int          arIdx = 0;

    bit          stallEn = 1'b0;
    int          errAt = -1;
    int          totalBeats = 0;

    bit          slvActive = 1'b0;
    logic [31:0] slvAddr = 32'd0;
    int          slvLen = 0;
    int          slvBeat = 0;
    int          arCnt = 0;
    int          rCnt = 0;
    bit          pendAr = 1'b0;
    bit          pendR = 1'b0;
    logic [31:0] pendArAddr = 32'd0;
    logic [7:0]  pendArLen = 8'd0;

    dram_line_reader #(.MAX_BURST(MAX_BURST)) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_kick          (kick),
        .i_read_addr     (readAddr),
        .i_read_num      (readNum),
        .o_busy          (busy),
        .o_buf_dout      (bufDout),
        .o_buf_we        (bufWe),
        .o_rd_err        (rdErr),
        .o_m_axi_araddr  (arAddr),
        .o_m_axi_arlen   (arLen),
        .o_m_axi_arsize  (arSize),
        .o_m_axi_arburst (arBurst),
        .o_m_axi_arvalid (arValid),
        .i_m_axi_arready (arReady),
        .i_m_axi_rdata   (rData),
        .i_m_axi_rresp   (rResp),
        .i_m_axi_rlast   (rLast),
        .i_m_axi_rvalid  (rValid),
        .o_m_axi_rready  (rReady)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dramWord(input logic [31:0] a);
        return ~a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Slave drives at negedge; handshakes decided here complete on the next posedge
    always @(negedge clk) begin
        if (!rstN) begin
            arReady = 1'b0; rValid = 1'b0; rLast = 1'b0; rResp = 2'b00; rData = 32'd0;
            slvActive = 1'b0; pendAr = 1'b0; pendR = 1'b0; arCnt = 0; rCnt = 0;
        end else begin
            if (pendAr) begin
                slvActive = 1'b1;
                slvAddr   = pendArAddr;
                slvLen    = int'(pendArLen);
                slvBeat   = 0;
                arAddrQ.push_back(pendArAddr);
                arLenQ.push_back(pendArLen);
                arCnt = stallEn ? int'($urandom_range(0, 7)) : 0;
            end
            if (pendR) begin
                slvBeat++;
                totalBeats++;
                rCnt = stallEn ? int'($urandom_range(0, 7)) : 0;
                if (slvBeat > slvLen) slvActive = 1'b0;
            end
            arReady = 1'b0;
            if (!slvActive) begin
                if (arCnt > 0) arCnt--;
                else arReady = 1'b1;
            end
            pendAr     = arValid && arReady;
            pendArAddr = arAddr;
            pendArLen  = arLen;
            rValid = 1'b0; rLast = 1'b0; rResp = 2'b00; rData = 32'd0;
            if (slvActive) begin
                if (rCnt > 0) rCnt--;
                else begin
                    rValid = 1'b1;
                    rData  = dramWord(slvAddr + 32'(slvBeat) * 32'd4);
                    rLast  = (slvBeat == slvLen);
                    rResp  = (totalBeats == errAt) ? 2'b10 : 2'b00;
                end
            end
            pendR = rValid && rReady;
        end
    end

    always @(negedge clk) begin
        if (rstN && bufWe) obsQ.push_back(bufDout);
    end

    task automatic startRequest(input logic [31:0] a, input int n);
        @(posedge clk); #1;
        readAddr = a;
        readNum  = n;
        kick     = 1'b1;
        for (int i = 0; i < n; i++) expQ.push_back(dramWord((a & 32'hFFFF_FFFC) + 32'(i) * 32'd4));
        @(posedge clk); #1;
        kick = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc, output bit done, output bit weAtFall);
        done = 1'b0;
        weAtFall = 1'b0;
        for (int c = 0; c < maxCyc; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                weAtFall = bufWe;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; kick = 1'b0; readAddr = 32'd0; readNum = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, bufWe, rdErr, arValid, rReady} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, bufWe, rdErr, arValid, rReady});
        end
        checks++;
        if (bufDout !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_dout: got %h expected 0", bufDout);
        end
        checks++;
        if ({arAddr, arLen} !== 40'd0) begin
            errors++; $display("[TB] FAIL reset_ar: got %h/%h expected 0/0", arAddr, arLen);
        end
        checks++;
        if (arSize !== 3'b010 || arBurst !== 2'b01) begin
            errors++; $display("[TB] FAIL ar_const: got size %b burst %b expected 010/01", arSize, arBurst);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic test_long_read();
        bit done, weFall;
        logic [31:0] e;
        stallEn = 1'b0;
        startRequest(32'h1000_0000, 1280);
        waitDone(3000, done, weFall);
        checks++;
        if (!done || !weFall) begin
            errors++; $display("[TB] FAIL long_done: got done=%0b weAtFall=%0b expected 1/1", done, weFall);
        end
        repeat (2) @(negedge clk);
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL long_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL long_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        expQ.delete(); obsIdx = obsQ.size();
        checks++;
        if (arAddrQ.size() - arIdx != 5) begin
            errors++; $display("[TB] FAIL long_ar_count: got %0d expected 5", arAddrQ.size() - arIdx);
        end
        for (int i = 0; i < 5 && arIdx + i < arAddrQ.size(); i++) begin
            checks++;
            if (arAddrQ[arIdx + i] !== 32'h1000_0000 + 32'(i) * 32'h400 || arLenQ[arIdx + i] !== 8'd255) begin
                errors++; $display("[TB] FAIL long_ar[%0d]: got %h/%0d expected %h/255", i, arAddrQ[arIdx + i], arLenQ[arIdx + i], 32'h1000_0000 + 32'(i) * 32'h400);
            end
        end
        arIdx = arAddrQ.size();
        checks++;
        if (rdErr !== 1'b0) begin
            errors++; $display("[TB] FAIL long_err: got %b expected 0", rdErr);
        end
    endtask

    task automatic test_4k_cross();
        bit done, weFall;
        logic [31:0] e;
        logic [31:0] eAddr[2];
        eAddr = '{32'h0000_0FF0, 32'h0000_1000};
        startRequest(32'h0000_0FF0, 8);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || arValid !== 1'b0) begin
            errors++; $display("[TB] FAIL calc_cycle: got busy=%b arvalid=%b expected 1/0", busy, arValid);
        end
        @(negedge clk);
        checks++;
        if (arValid !== 1'b1 || arAddr !== 32'h0FF0 || arLen !== 8'd3) begin
            errors++; $display("[TB] FAIL addr_cycle: got %b %h %0d expected 1 00000ff0 3", arValid, arAddr, arLen);
        end
        waitDone(200, done, weFall);
        checks++;
        if (!done || !weFall) begin
            errors++; $display("[TB] FAIL cross_done: got done=%0b weAtFall=%0b expected 1/1", done, weFall);
        end
        repeat (2) @(negedge clk);
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL cross_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL cross_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        expQ.delete(); obsIdx = obsQ.size();
        checks++;
        if (arAddrQ.size() - arIdx != 2) begin
            errors++; $display("[TB] FAIL cross_ar_count: got %0d expected 2", arAddrQ.size() - arIdx);
        end
        for (int i = 0; i < 2 && arIdx + i < arAddrQ.size(); i++) begin
            checks++;
            if (arAddrQ[arIdx + i] !== eAddr[i] || arLenQ[arIdx + i] !== 8'd3) begin
                errors++; $display("[TB] FAIL cross_ar[%0d]: got %h/%0d expected %h/3", i, arAddrQ[arIdx + i], arLenQ[arIdx + i], eAddr[i]);
            end
        end
        arIdx = arAddrQ.size();
    endtask

    task automatic test_zero_and_ignore();
        bit done, weFall, sawBusy;
        logic [31:0] e;
        startRequest(32'h0000_0100, 0);
        sawBusy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sawBusy |= busy | arValid;
        end
        checks++;
        if (sawBusy || arAddrQ.size() != arIdx) begin
            errors++; $display("[TB] FAIL zero_num: got busy_seen=%0b new_ar=%0d expected 0/0", sawBusy, arAddrQ.size() - arIdx);
        end
        startRequest(32'h0000_3000, 16);
        repeat (3) @(posedge clk);
        #1;
        // second edge while busy must neither queue nor disturb the first request
        kick = 1'b1; readAddr = 32'h0000_9000; readNum = 50;
        @(posedge clk); #1;
        kick = 1'b0;
        waitDone(500, done, weFall);
        checks++;
        if (!done || !weFall) begin
            errors++; $display("[TB] FAIL ignore_done: got done=%0b weAtFall=%0b expected 1/1", done, weFall);
        end
        sawBusy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sawBusy |= busy | arValid;
        end
        checks++;
        if (sawBusy) begin
            errors++; $display("[TB] FAIL ignore_queued: got busy after done=1 expected 0");
        end
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL ignore_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL ignore_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        expQ.delete(); obsIdx = obsQ.size();
        checks++;
        if (arAddrQ.size() - arIdx != 1 || arAddrQ[arAddrQ.size() - 1] !== 32'h3000 || arLenQ[arLenQ.size() - 1] !== 8'd15) begin
            errors++; $display("[TB] FAIL ignore_ar: got %0d ARs expected 1 at 00003000/15", arAddrQ.size() - arIdx);
        end
        arIdx = arAddrQ.size();
    endtask

    task automatic test_back_to_back();
        bit done, weFall;
        logic [31:0] e;
        startRequest(32'h0000_4000, 4);
        waitDone(200, done, weFall);
        checks++;
        if (!done || !weFall) begin
            errors++; $display("[TB] FAIL b2b_first: got done=%0b weAtFall=%0b expected 1/1", done, weFall);
        end
        // new edge presented in the very cycle busy falls
        kick = 1'b1; readAddr = 32'h0000_4100; readNum = 4;
        for (int i = 0; i < 4; i++) expQ.push_back(dramWord(32'h0000_4100 + 32'(i) * 32'd4));
        @(posedge clk); #1;
        kick = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        waitDone(200, done, weFall);
        checks++;
        if (!done || !weFall) begin
            errors++; $display("[TB] FAIL b2b_second: got done=%0b weAtFall=%0b expected 1/1", done, weFall);
        end
        repeat (2) @(negedge clk);
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL b2b_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        expQ.delete(); obsIdx = obsQ.size();
        arIdx = arAddrQ.size();
    endtask

    task automatic test_resp_error();
        bit done, weFall;
        logic [31:0] e;
        checks++;
        if (rdErr !== 1'b0) begin
            errors++; $display("[TB] FAIL err_pre: got %b expected 0", rdErr);
        end
        errAt = totalBeats + 5;
        startRequest(32'h0000_5000, 16);
        waitDone(300, done, weFall);
        errAt = -1;
        checks++;
        if (!done || rdErr !== 1'b1) begin
            errors++; $display("[TB] FAIL err_set: got done=%0b rd_err=%b expected 1/1", done, rdErr);
        end
        startRequest(32'h0000_6000, 8);
        waitDone(300, done, weFall);
        checks++;
        if (!done || !weFall || rdErr !== 1'b1) begin
            errors++; $display("[TB] FAIL err_sticky: got done=%0b we=%0b rd_err=%b expected 1/1/1", done, weFall, rdErr);
        end
        repeat (2) @(negedge clk);
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL err_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL err_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        expQ.delete(); obsIdx = obsQ.size();
        arIdx = arAddrQ.size();
    endtask

    task automatic test_random_stalls();
        bit done, weFall;
        logic [31:0] e;
        logic [31:0] eAddr[4];
        logic [7:0]  eLen[4];
        eAddr = '{32'h2000_0F00, 32'h2000_1000, 32'h2000_1400, 32'h2000_1800};
        eLen  = '{8'd63, 8'd255, 8'd255, 8'd23};
        stallEn = 1'b1;
        startRequest(32'h2000_0F00, 600);
        waitDone(20000, done, weFall);
        stallEn = 1'b0;
        checks++;
        if (!done || !weFall) begin
            errors++; $display("[TB] FAIL stall_done: got done=%0b weAtFall=%0b expected 1/1", done, weFall);
        end
        repeat (2) @(negedge clk);
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL stall_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL stall_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        expQ.delete(); obsIdx = obsQ.size();
        checks++;
        if (arAddrQ.size() - arIdx != 4) begin
            errors++; $display("[TB] FAIL stall_ar_count: got %0d expected 4", arAddrQ.size() - arIdx);
        end
        for (int i = 0; arIdx + i < arAddrQ.size(); i++) begin
            checks++;
            if (int'(arAddrQ[arIdx + i][11:0]) + (int'(arLenQ[arIdx + i]) + 1) * 4 > 4096 || int'(arLenQ[arIdx + i]) > MAX_BURST - 1) begin
                errors++; $display("[TB] FAIL stall_4k[%0d]: got %h/%0d expected within 4 KB page", i, arAddrQ[arIdx + i], arLenQ[arIdx + i]);
            end
            if (i < 4) begin
                checks++;
                if (arAddrQ[arIdx + i] !== eAddr[i] || arLenQ[arIdx + i] !== eLen[i]) begin
                    errors++; $display("[TB] FAIL stall_ar[%0d]: got %h/%0d expected %h/%0d", i, arAddrQ[arIdx + i], arLenQ[arIdx + i], eAddr[i], eLen[i]);
                end
            end
        end
        arIdx = arAddrQ.size();
    endtask

    task automatic test_reset_mid();
        bit done, weFall, reached;
        logic [31:0] e;
        startRequest(32'h0000_7000, 64);
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (obsQ.size() - obsIdx >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached || rReady !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_reach: got reached=%0b rready=%b expected 1/1", reached, rReady);
        end
        @(posedge clk); #1;
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, bufWe, rdErr, arValid, rReady} !== 5'b0 || bufDout !== 32'd0 || {arAddr, arLen} !== 40'd0) begin
            errors++; $display("[TB] FAIL mid_reset: got ctrl=%b dout=%h ar=%h/%h expected all 0", {busy, bufWe, rdErr, arValid, rReady}, bufDout, arAddr, arLen);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        expQ.delete(); obsIdx = obsQ.size(); arIdx = arAddrQ.size();
        startRequest(32'h0000_8000, 16);
        waitDone(300, done, weFall);
        checks++;
        if (!done || !weFall || rdErr !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_after: got done=%0b we=%0b rd_err=%b expected 1/1/0", done, weFall, rdErr);
        end
        repeat (2) @(negedge clk);
        while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ[obsIdx] !== e) begin
                errors++; $display("[TB] FAIL mid_word[%0d]: got %h expected %h", obsIdx, obsQ[obsIdx], e);
            end
            obsIdx++;
        end
        checks++;
        if (expQ.size() != 0 || obsIdx != obsQ.size()) begin
            errors++; $display("[TB] FAIL mid_count: got %0d missing %0d extra, expected 0/0", expQ.size(), obsQ.size() - obsIdx);
        end
        checks++;
        if (arAddrQ.size() - arIdx != 1 || arAddrQ[arAddrQ.size() - 1] !== 32'h8000 || arLenQ[arLenQ.size() - 1] !== 8'd15) begin
            errors++; $display("[TB] FAIL mid_ar: got %0d ARs expected 1 at 00008000/15", arAddrQ.size() - arIdx);
        end
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_long_read();
        test_4k_cross();
        test_zero_and_ignore();
        test_back_to_back();
        test_resp_error();
        test_random_stalls();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_line_reader.md
# dram_line_reader

AXI4 read master that fetches one video line (or any run of 32-bit words) from DRAM on a `kick` request and streams the words out as `buf_dout`/`buf_we`. It sits directly upstream of the HDMI output stage. It consumes the `kick`/`read_addr`/`read_num` request and returns `busy` plus the pixel-word stream that is written into the line FIFO. It splits each request into AXI INCR bursts of at most `MAX_BURST` beats that never cross a 4 KB boundary, with one burst outstanding at a time.

## Interface
- `MAX_BURST`, default 256: maximum beats per burst; power of two, 1..256.
- `clk` in 1: single clock for all logic, including the AXI side.
- `rst_n` in 1: synchronous, active-low reset.
- `kick` in 1: request strobe; a rising edge starts a request.
- `read_addr` in 32: byte start address; bits [1:0] are ignored and treated as 0.
- `read_num` in 32: number of 32-bit words to read.
- `busy` out 1: request in progress.
- `buf_dout` out 32: read word; pixel in [31:8].
- `buf_we` out 1: `buf_dout` valid, one word per cycle.
- `rd_err` out 1: sticky error flag; cleared only by reset.
- `m_axi_araddr` out 32, `m_axi_arlen` out 8, `m_axi_arsize` out 3 (constant 3'b010), `m_axi_arburst` out 2 (constant 2'b01).
- `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1.

## Operation
- Edge detect: `kick` is registered as `kick_d`. A start is `kick & ~kick_d` while the block is in IDLE.
  - Edges seen outside IDLE are ignored and do not queue.
  - A start with `read_num == 0` is ignored; `busy` stays 0.
- On start, latch `addr = {read_addr[31:2], 2'b00}` and `remain = read_num`.
- States:
  - **IDLE**: waits for a start; on start go to CALC.
  - **CALC**: compute the beat count for the next burst.
    - `to4k = 1024 - addr[11:2]` (11-bit, range 1..1024).
    - `beats = min(remain, MAX_BURST, to4k)`.
    - Register `m_axi_araddr = addr` and `m_axi_arlen = beats - 1`, then go to ADDR.
  - **ADDR**: `m_axi_arvalid = 1`. On `arready` go to DATA, then:
    - `addr += beats * 4`,
    - `remain -= beats`,
    - beat counter `bcnt = 0`.
  - **DATA**: `m_axi_rready = 1`. Each `rvalid` beat increments `bcnt`.
    - On the beat where `bcnt == arlen`: if `remain == 0` go to IDLE, else go to CALC.
- Output path is registered: `buf_dout <= rdata` and `buf_we <= rvalid & rready`. The block applies no backpressure; the downstream FIFO must absorb 1 word per cycle.
- `rd_err` is set by any of:
  - `rresp != 2'b00` on any accepted beat,
  - `rlast` = 1 on a beat other than the counted last beat,
  - `rlast` = 0 on the counted last beat.
- Data is still forwarded when `rd_err` is set, and burst termination always follows `bcnt`, never `rlast`.
- `remain` is 32-bit unsigned and `addr` wraps modulo 2^32.

## Timing
- Reset values: `busy`, `buf_we`, `rd_err`, `m_axi_arvalid`, `m_axi_rready` are 0; `buf_dout`, `m_axi_araddr`, `m_axi_arlen` are 0; state is IDLE.
- Start edge sampled at cycle N:
  - `busy` = 1 at N+1 (CALC),
  - `m_axi_arvalid` = 1 at N+2.
- `arvalid` stays high, with `araddr`/`arlen` stable, until `arready` is sampled high.
- `rready` = 1 from the cycle after the AR handshake through the last beat of the burst.
- `buf_we` follows an accepted R beat by 1 cycle.
- Between bursts, the cycle after the last beat is CALC and the cycle after that is ADDR.
- `busy` falls in the same cycle the final `buf_we` is asserted. The next start is accepted from that cycle onward.
- Reset mid-operation:
  - All outputs return to their reset values on the next edge and any in-flight burst is abandoned.
  - The interconnect must be reset together with this block.

## Test plan
- `read_addr=0x1000_0000`, `read_num=1280`, `arready`/`rvalid` always 1 → 5 bursts with `arlen=255` at 0x1000_0000, +0x400, +0x800, +0xC00, +0x1000; 1280 `buf_we` pulses carrying data in order; `busy` high for the whole request; `rd_err=0`.
- 4 KB crossing: `read_addr=0x0000_0FF0`, `read_num=8` → AR at 0x0FF0 with `arlen=3`, then AR at 0x1000 with `arlen=3`; 8 words out.
- `read_num=0` kick → no AR, `busy` stays 0. Kick edge while `busy` → ignored, with exactly one request's worth of words out.
- `rresp=2'b10` on beat 5 of a 16-word read → `rd_err` goes to 1 and stays there; all 16 words are still output; a second request completes normally with `rd_err` still 1.
- Random `arready`/`rvalid` stalls of 0–7 cycles on a 600-word read at 0x2000_0F00 → word count and order match the DRAM model; no burst crosses a 4 KB boundary; `arlen ≤ MAX_BURST-1`.
- `rst_n` low during DATA → all outputs 0 on the next cycle; after release and a new kick, a 16-word read completes correctly.
